// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flop cells with JK-register, up/down counter and
// shift-left modes, plus synchronous reset, preset and parallel load.
module jk_reg_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_t;

  mode_t            mode_sel;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;

  assign mode_sel = mode_t'(mode);

  // T-cell toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  end

  // Next state for an enabled cycle in the selected mode
  always_comb begin
    next_q    = q;
    next_wrap = 1'b0;
    case (mode_sel)
      MODE_JK: next_q = (j & ~q) | (~k & q);
      MODE_UP: begin
        if (q >= MAX_Q) begin
          next_q    = '0;
          next_wrap = 1'b1;
        end else begin
          next_q = q ^ up_t;
        end
      end
      MODE_DOWN: begin
        if (q == '0) begin
          next_q    = MAX_Q;
          next_wrap = 1'b1;
        end else begin
          next_q = q ^ dn_t;
        end
      end
      MODE_SHIFT: next_q = {q[WIDTH-2:0], sin};
      default: next_q = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (!set) begin
      q    <= '1;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= next_q;
      wrap <= next_wrap;
    end else begin
      q    <= q;
      wrap <= 1'b0;
    end
  end

  assign qb = ~q;

  // Terminal count follows q and mode only; en does not gate it
  always_comb begin
    tc = 1'b0;
    case (mode_sel)
      MODE_UP:   tc = (q >= MAX_Q);
      MODE_DOWN: tc = (q == '0);
      default:   tc = 1'b0;
    endcase
  end

endmodule
